// File: rtl/quat_pkg.sv
// Shared definitions for the sequential quaternion multiplier: component width,
// FSM states and the 16-step Hamilton-product schedule.
package quat_pkg;

  localparam int DATA_W = 16;
  localparam int QUAT_W = 4 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Component indices: 0=w, 1=x, 2=y, 3=z.
  typedef struct packed {
    logic [1:0] p_idx;
    logic [1:0] q_idx;
    logic [1:0] comp;
    logic       neg;
  } sched_t;

  function automatic sched_t schedule(input logic [3:0] step);
    case (step)
      4'd0:    return sched_t'{2'd0, 2'd0, 2'd0, 1'b0};
      4'd1:    return sched_t'{2'd1, 2'd1, 2'd0, 1'b1};
      4'd2:    return sched_t'{2'd2, 2'd2, 2'd0, 1'b1};
      4'd3:    return sched_t'{2'd3, 2'd3, 2'd0, 1'b1};
      4'd4:    return sched_t'{2'd0, 2'd1, 2'd1, 1'b0};
      4'd5:    return sched_t'{2'd1, 2'd0, 2'd1, 1'b0};
      4'd6:    return sched_t'{2'd2, 2'd3, 2'd1, 1'b0};
      4'd7:    return sched_t'{2'd3, 2'd2, 2'd1, 1'b1};
      4'd8:    return sched_t'{2'd0, 2'd2, 2'd2, 1'b0};
      4'd9:    return sched_t'{2'd1, 2'd3, 2'd2, 1'b1};
      4'd10:   return sched_t'{2'd2, 2'd0, 2'd2, 1'b0};
      4'd11:   return sched_t'{2'd3, 2'd1, 2'd2, 1'b0};
      4'd12:   return sched_t'{2'd0, 2'd3, 2'd3, 1'b0};
      4'd13:   return sched_t'{2'd1, 2'd2, 2'd3, 1'b0};
      4'd14:   return sched_t'{2'd2, 2'd1, 2'd3, 1'b1};
      default: return sched_t'{2'd3, 2'd0, 2'd3, 1'b0};
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [QUAT_W-1:0] v,
                                             input logic [1:0] idx);
    case (idx)
      2'd0:    return v[4*DATA_W-1 -: DATA_W];
      2'd1:    return v[3*DATA_W-1 -: DATA_W];
      2'd2:    return v[2*DATA_W-1 -: DATA_W];
      default: return v[DATA_W-1 -: DATA_W];
    endcase
  endfunction

endpackage

// File: rtl/quat_product_seq_if.sv
// Operand/product bus between the sequencer and its combinational multiplier.
interface quat_product_seq_if #(parameter int W = 16);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;

    modport master (output a, output b, input p);
    modport slave  (input a, input b, output p);
endinterface

// File: rtl/quat_product_seq_multiplication.sv
// Combinational signed multiplier returning only the low DATA_W bits of the product.
module multiplication
    import quat_pkg::*;
(
    quat_product_seq_if.slave mul
);
    // Low half of a product is identical for signed and unsigned operands.
    assign mul.p = DATA_W'($signed(mul.a) * $signed(mul.b));
endmodule

// File: rtl/quat_product_seq.sv
// Sequential Hamilton product R=P*Q, one 16x16 multiply per cycle over 16 steps.
// Optional QPROD_SAT_EN: 18-bit accumulators with clamping to 16-bit signed on output.
module quat_product_seq
    import quat_pkg::*;
#(
    parameter int DATA_W = quat_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DATA_W-1:0] p_in,
    input  logic [4*DATA_W-1:0] q_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DATA_W-1:0] r_out,
    output logic                busy,
    output state_t              fsm_state
);

`ifdef QPROD_SAT_EN
    localparam int ACC_W = DATA_W + 2;
`else
    localparam int ACC_W = DATA_W;
`endif

    state_t                   state, state_nxt;
    logic [3:0]               step;
    logic [4*DATA_W-1:0]      p_reg, q_reg;
    logic signed [ACC_W-1:0]  acc     [4];
    logic signed [ACC_W-1:0]  acc_nxt [4];
    logic signed [ACC_W-1:0]  prod_ext;
    logic [4*DATA_W-1:0]      r_nxt;
    sched_t                   sc;

    quat_product_seq_if #(.W(DATA_W)) mul_bus ();
    multiplication u_mul (.mul(mul_bus.slave));

    assign sc        = schedule(step);
    assign mul_bus.a = pick(p_reg, sc.p_idx);
    assign mul_bus.b = pick(q_reg, sc.q_idx);

`ifdef QPROD_SAT_EN
    assign prod_ext = {{(ACC_W-DATA_W){mul_bus.p[DATA_W-1]}}, mul_bus.p};

    function automatic logic [DATA_W-1:0] clamp(input logic signed [ACC_W-1:0] v);
        logic [ACC_W-DATA_W:0] top;
        top = v[ACC_W-1:DATA_W-1];
        if ((&top) || !(|top)) return v[DATA_W-1:0];
        return v[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

    assign r_nxt = {clamp(acc_nxt[0]), clamp(acc_nxt[1]), clamp(acc_nxt[2]), clamp(acc_nxt[3])};
`else
    assign prod_ext = mul_bus.p;
    assign r_nxt    = {acc_nxt[0], acc_nxt[1], acc_nxt[2], acc_nxt[3]};
`endif

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and out data is stable while out_valid.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == MAC);
    assign fsm_state = state;

    always_comb begin
        for (int i = 0; i < 4; i++) acc_nxt[i] = acc[i];
        if (state == MAC)
            acc_nxt[sc.comp] = sc.neg ? acc[sc.comp] - prod_ext : acc[sc.comp] + prod_ext;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MAC;
            MAC:     if (step == 4'd15) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= '0;
            p_reg <= '0;
            q_reg <= '0;
            r_out <= '0;
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                p_reg <= p_in;
                q_reg <= q_in;
                step  <= '0;
                for (int i = 0; i < 4; i++) acc[i] <= '0;
            end else if (state == MAC) begin
                step <= step + 4'd1;
                for (int i = 0; i < 4; i++) acc[i] <= acc_nxt[i];
                // The final step's product is folded in combinationally so latency stays 16.
                if (step == 4'd15) r_out <= r_nxt;
            end
        end
    end

endmodule

// File: tb/tb_quat_product_seq.sv
// Directed bench for quat_product_seq: latency, Hamilton product vectors, backpressure, reset abort.
module tb_quat_product_seq;
    import quat_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] p_in = '0;
    logic [63:0] q_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] r_out;
    logic        busy;
    state_t      fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    quat_product_seq #(.DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .p_in(p_in), .q_in(q_in), .out_valid(out_valid), .out_ready(out_ready),
        .r_out(r_out), .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] q4(input logic [15:0] w, x, y, z);
        return {w, x, y, z};
    endfunction

    task automatic start_op(input logic [63:0] p, input logic [63:0] q);
        @(negedge clk);
        p_in = p;
        q_in = q;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (r_out !== 64'h0) begin n_bad++; $display("FAIL reset_r_out got %h want 0", r_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (fsm_state !== IDLE) begin n_bad++; $display("FAIL reset_state got %0d want IDLE", fsm_state); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        int lat;
        logic [63:0] exp_r;
        exp_r = q4(16'd3, 16'd4, 16'd5, 16'd6);
        start_op(q4(16'd1, 16'd0, 16'd0, 16'd0), exp_r);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ident_busy got %b want 1", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ident_in_ready got %b want 0", in_ready); end
        wait_done(lat);
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL ident_latency got %0d want 16", lat); end
        n_cmp++; if (r_out !== exp_r) begin n_bad++; $display("FAIL ident_r got %h want %h", r_out, exp_r); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ident_busy_done got %b want 0", busy); end
        drain();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL ident_drain got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
        n_cmp++; if (r_out !== exp_r) begin n_bad++; $display("FAIL ident_r_hold got %h want %h", r_out, exp_r); end
    endtask

    task automatic test_basis();
        int lat;
        start_op(q4(16'd0, 16'd1, 16'd0, 16'd0), q4(16'd0, 16'd0, 16'd1, 16'd0));
        wait_done(lat);
        n_cmp++; if (r_out !== 64'h0000_0000_0000_0001 || lat !== 16) begin n_bad++; $display("FAIL basis_ij got %h lat %0d want 0000000000000001 lat 16", r_out, lat); end
        drain();
        start_op(q4(16'd0, 16'd0, 16'd1, 16'd0), q4(16'd0, 16'd1, 16'd0, 16'd0));
        wait_done(lat);
        n_cmp++; if (r_out !== 64'h0000_0000_0000_FFFF || lat !== 16) begin n_bad++; $display("FAIL basis_ji got %h lat %0d want 000000000000ffff lat 16", r_out, lat); end
        drain();
    endtask

    task automatic test_general();
        int lat;
        logic [63:0] exp_r;
        exp_r = q4(16'hFFC4, 16'd12, 16'd30, 16'd24);
        start_op(q4(16'd1, 16'd2, 16'd3, 16'd4), q4(16'd5, 16'd6, 16'd7, 16'd8));
        wait_done(lat);
        n_cmp++; if (r_out !== exp_r) begin n_bad++; $display("FAIL general_r got %h want %h", r_out, exp_r); end
        drain();
    endtask

    task automatic test_overflow();
        int lat;
        logic [63:0] exp_r;
`ifdef QPROD_SAT_EN
        exp_r = q4(16'h8000, 16'd0, 16'd0, 16'd0);
`else
        exp_r = q4(16'h4000, 16'd0, 16'd0, 16'd0);
`endif
        start_op(q4(16'd0, 16'd128, 16'd128, 16'd128), q4(16'd0, 16'd128, 16'd128, 16'd128));
        wait_done(lat);
        n_cmp++; if (r_out !== exp_r) begin n_bad++; $display("FAIL overflow_r got %h want %h", r_out, exp_r); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [63:0] exp_r;
        exp_r = q4(16'hFFC4, 16'd12, 16'd30, 16'd24);
        start_op(q4(16'd1, 16'd2, 16'd3, 16'd4), q4(16'd5, 16'd6, 16'd7, 16'd8));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            p_in = 64'(i + 7) * 64'h0001_0003_0005_0007;
            q_in = 64'h1234_5678_9ABC_DEF0;
            @(posedge clk);
            #1;
            n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL bp_mac_ready got ir=%b busy=%b want ir=0 busy=1", in_ready, busy); end
        end
        in_valid = 1'b0;
        wait_done(lat);
        n_cmp++; if (lat + 5 !== 16) begin n_bad++; $display("FAIL bp_latency got %0d want 16", lat + 5); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b1 || r_out !== exp_r || in_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold got ov=%b r=%h ir=%b want ov=1 r=%h ir=0", out_valid, r_out, in_ready, exp_r);
            end
        end
        in_valid = 1'b0;
        drain();
        n_cmp++; if (fsm_state !== IDLE || r_out !== exp_r) begin n_bad++; $display("FAIL bp_after got state=%0d r=%h want IDLE r=%h", fsm_state, r_out, exp_r); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit seen;
        logic [63:0] exp_r;
        exp_r = q4(16'hFFC4, 16'd12, 16'd30, 16'd24);
        start_op(q4(16'd3, 16'd3, 16'd3, 16'd3), q4(16'd2, 16'd2, 16'd2, 16'd2));
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || r_out !== 64'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL midrst_outputs got ov=%b r=%h busy=%b ir=%b want 0 0 0 1", out_valid, r_out, busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_spurious got out_valid seen want none"); end
        start_op(q4(16'd1, 16'd2, 16'd3, 16'd4), q4(16'd5, 16'd6, 16'd7, 16'd8));
        wait_done(lat);
        n_cmp++; if (r_out !== exp_r || lat !== 16) begin n_bad++; $display("FAIL midrst_new got %h lat %0d want %h lat 16", r_out, lat, exp_r); end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_basis();
        test_general();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
